// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int DEF_NUM_PORTS  = 2;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Width of a port index; a single-port build still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requests are held until req_resp; memory completes with mem_resp.
// Modports: slave = arbiter view, master = requesters + memory model view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
);

  // Requester side (one lane per port).
  logic [NUM_PORTS-1:0]                  req_read;
  logic [NUM_PORTS-1:0]                  req_write;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_address;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata;
  logic [NUM_PORTS-1:0][MASK_WIDTH-1:0]  req_wmask;
  logic [NUM_PORTS-1:0]                  req_resp;
  logic [DATA_WIDTH-1:0]                 req_rdata;

  // Memory side (single downstream channel).
  logic                                  mem_read;
  logic                                  mem_write;
  logic [ADDR_WIDTH-1:0]                 mem_address;
  logic [DATA_WIDTH-1:0]                 mem_wdata;
  logic [MASK_WIDTH-1:0]                 mem_wmask;
  logic                                  mem_resp;
  logic [DATA_WIDTH-1:0]                 mem_rdata;

  modport slave (
    input  req_read, req_write, req_address, req_wdata, req_wmask,
    output req_resp, req_rdata,
    output mem_read, mem_write, mem_address, mem_wdata, mem_wmask,
    input  mem_resp, mem_rdata
  );

  modport master (
    output req_read, req_write, req_address, req_wdata, req_wmask,
    input  req_resp, req_rdata,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_wmask,
    output mem_resp, mem_rdata
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first pending port after last_grant.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; any_valid low means nothing to grant.
// Ports: pending (per-port request), last_grant (index) -> grant (index), any_valid.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [IDX_W-1:0]     grant,
  output logic                 any_valid
);

  // (base + off) mod NUM_PORTS with off in 1..NUM_PORTS; one wrap is enough.
  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return IDX_W'(sum);
  endfunction

  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    // Walk from the farthest offset to the nearest so the nearest pending
    // port after last_grant is the one left standing.
    for (int off = NUM_PORTS; off >= 1; off--) begin
      if (pending[rot_idx(last_grant, off)]) begin
        grant     = rot_idx(last_grant, off);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory channel among NUM_PORTS requesters.
// Latency: grant at end of IDLE cycle t, mem strobe from t+1, req_resp the cycle after mem_resp (min 3).
// Backpressure: one transaction in flight; other ports wait with requests held until their req_resp.
// Ports: clk, rst_n (async active-low), bus (mem_port_arbiter_if.slave: req_* lanes, mem_* channel).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       grant_q;
  logic [IDX_W-1:0]       last_grant_q;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_vld;
  logic                   take_grant;
  logic [NUM_PORTS-1:0]   pending;
  logic [NUM_PORTS-1:0]   resp;

  logic                   mem_read_q;
  logic                   mem_write_q;
  logic [ADDR_WIDTH-1:0]  mem_address_q;
  logic [DATA_WIDTH-1:0]  mem_wdata_q;
  logic [MASK_WIDTH-1:0]  mem_wmask_q;
  logic [DATA_WIDTH-1:0]  rdata_q;

  assign pending = bus.req_read | bus.req_write;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .pending    (pending),
    .last_grant (last_grant_q),
    .grant      (pick_idx),
    .any_valid  (pick_vld)
  );

  // Next-state logic. mem_resp only matters in BUSY, so strays elsewhere drop out here.
  always_comb begin
    state_d    = state_q;
    take_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = BUSY;
          take_grant = 1'b1;
        end
      end
      BUSY:    if (bus.mem_resp) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completion pulse is decoded from state so reset kills it immediately.
  always_comb begin
    resp = '0;
    if (state_q == RESP) resp[grant_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_grant_q  <= IDX_W'(NUM_PORTS - 1);
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_wmask_q   <= '0;
      rdata_q       <= '0;
    end else begin
      state_q <= state_d;
      if (take_grant) begin
        // Fields are captured once here and frozen for the whole BUSY phase.
        grant_q       <= pick_idx;
        last_grant_q  <= pick_idx;
        mem_write_q   <= bus.req_write[pick_idx];
        // Read+write together is treated as a write.
        mem_read_q    <= bus.req_read[pick_idx] & ~bus.req_write[pick_idx];
        mem_address_q <= bus.req_address[pick_idx];
        mem_wdata_q   <= bus.req_wdata[pick_idx];
        mem_wmask_q   <= bus.req_wmask[pick_idx];
      end else if ((state_q == BUSY) && bus.mem_resp) begin
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
        if (mem_read_q) rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.req_resp    = resp;
  assign bus.req_rdata   = rdata_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_wmask   = mem_wmask_q;

endmodule
